// File: rtl/stoch_patch_pkg.sv
// rtl/stoch_patch_pkg.sv - shared state encoding and geometry helpers for the patch scheduler
package stoch_patch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of patch positions along one axis, including zero padding.
  function automatic int out_dim(int in_dim, int patch, int stride, int pad);
    return (in_dim + 2 * pad - patch) / stride + 1;
  endfunction

  // Signed width wide enough for any origin from -pad up to the far edge.
  function automatic int base_width(int w, int h, int pad);
    int m;
    m = (w > h) ? w : h;
    return $clog2(m + pad + 1) + 1;
  endfunction

endpackage

// File: rtl/stoch_wrap_counter.sv
// rtl/stoch_wrap_counter.sv - modulo-MAX counter whose wrap output chains into the next stage
module stoch_wrap_counter #(
  parameter int MAX = 4,
  localparam int W = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         CLK,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         wrap
);

  assign wrap = inc && (value == W'(MAX - 1));

  always_ff @(posedge CLK) begin
    if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= wrap ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/stoch_patch_scheduler.sv
// rtl/stoch_patch_scheduler.sv - walks patch origins over a padded array, holding each
// origin for STREAM_LEN accepted stochastic-bit cycles
module stoch_patch_scheduler
  import stoch_patch_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int HEIGHT     = 32,
  parameter int PATCH_W    = 3,
  parameter int PATCH_H    = 3,
  parameter int STRIDE     = 1,
  parameter int PAD        = 1,
  parameter int STREAM_LEN = 256,
  localparam int BW = base_width(WIDTH, HEIGHT, PAD)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 ready,
  output logic signed [BW-1:0] base_h,
  output logic signed [BW-1:0] base_w,
  output logic                 stream_en,
  output logic                 patch_last,
  output logic                 busy,
  output logic                 done
);

  localparam int OUT_H = out_dim(HEIGHT, PATCH_H, STRIDE, PAD);
  localparam int OUT_W = out_dim(WIDTH, PATCH_W, STRIDE, PAD);
  localparam int CNT_W = (STREAM_LEN > 1) ? $clog2(STREAM_LEN) : 1;
  localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  state_t state, next;

  logic             run_en;
  logic             clr;
  logic [CNT_W-1:0] cnt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             cnt_wrap, col_wrap, row_wrap;

  // Counters are only meaningful in RUN; holding them clear elsewhere makes
  // every scan start at the first origin with cnt=0.
  assign run_en = (state == RUN) && ready;
  assign clr    = RST || (state != RUN);

  stoch_wrap_counter #(.MAX(STREAM_LEN)) u_cnt (
    .CLK(CLK), .clr(clr), .inc(run_en), .value(cnt), .wrap(cnt_wrap)
  );

  stoch_wrap_counter #(.MAX(OUT_W)) u_col (
    .CLK(CLK), .clr(clr), .inc(cnt_wrap), .value(col), .wrap(col_wrap)
  );

  stoch_wrap_counter #(.MAX(OUT_H)) u_row (
    .CLK(CLK), .clr(clr), .inc(col_wrap), .value(row), .wrap(row_wrap)
  );

  assign patch_last = cnt_wrap;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  // row_wrap already implies the final beat of the final patch.
  always_comb begin
    next      = state;
    busy      = 1'b0;
    done      = 1'b0;
    stream_en = 1'b0;
    base_h    = '0;
    base_w    = '0;
    case (state)
      IDLE: begin
        if (start) next = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        stream_en = run_en;
        base_h    = BW'(int'(row) * STRIDE - PAD);
        base_w    = BW'(int'(col) * STRIDE - PAD);
        if (abort) begin
          next = IDLE;
        end else if (row_wrap) begin
          next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stoch_patch_scheduler.sv
// tb/tb_stoch_patch_scheduler.sv - scoreboard bench for the stochastic patch scheduler
module tb_stoch_patch_scheduler;
  import stoch_patch_pkg::*;

  localparam int BW1 = base_width(4, 4, 1);
  localparam int BW2 = base_width(5, 5, 0);

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic start = 1'b0, abort = 1'b0, ready = 1'b0;
  logic start2 = 1'b0, abort2 = 1'b0, ready2 = 1'b0;

  logic signed [BW1-1:0] base_h, base_w;
  logic stream_en, patch_last, busy, done;
  logic signed [BW2-1:0] base_h2, base_w2;
  logic stream_en2, patch_last2, busy2, done2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int bh;
    int bw;
    bit last;
  } beat_t;

  beat_t sb[$];

  always #5 CLK = ~CLK;

  stoch_patch_scheduler #(
    .WIDTH(4), .HEIGHT(4), .PATCH_W(3), .PATCH_H(3),
    .STRIDE(1), .PAD(1), .STREAM_LEN(4)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .ready(ready),
    .base_h(base_h), .base_w(base_w), .stream_en(stream_en),
    .patch_last(patch_last), .busy(busy), .done(done)
  );

  stoch_patch_scheduler #(
    .WIDTH(5), .HEIGHT(5), .PATCH_W(3), .PATCH_H(3),
    .STRIDE(2), .PAD(0), .STREAM_LEN(2)
  ) dut2 (
    .CLK(CLK), .RST(RST), .start(start2), .abort(abort2), .ready(ready2),
    .base_h(base_h2), .base_w(base_w2), .stream_en(stream_en2),
    .patch_last(patch_last2), .busy(busy2), .done(done2)
  );

  function automatic void push_scan(int oh, int ow, int s, int pad, int len);
    beat_t b;
    for (int r = 0; r < oh; r++)
      for (int c = 0; c < ow; c++)
        for (int k = 0; k < len; k++) begin
          b.bh = r * s - pad;
          b.bw = c * s - pad;
          b.last = (k == len - 1);
          sb.push_back(b);
        end
  endfunction

  task automatic test_reset();
    RST = 1'b1; start = 1'b1; ready = 1'b1; start2 = 1'b1; ready2 = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", done); end
    n_checks++; if (stream_en !== 1'b0) begin n_fail++; $display("FAIL reset_stream_en got %b expected 0", stream_en); end
    n_checks++; if (patch_last !== 1'b0) begin n_fail++; $display("FAIL reset_patch_last got %b expected 0", patch_last); end
    n_checks++; if (base_h !== 0 || base_w !== 0) begin n_fail++; $display("FAIL reset_base got (%0d,%0d) expected (0,0)", base_h, base_w); end
    n_checks++; if (busy2 !== 1'b0 || stream_en2 !== 1'b0) begin n_fail++; $display("FAIL reset_dut2 got busy=%b en=%b expected 0 0", busy2, stream_en2); end
    @(negedge CLK);
    RST = 1'b0; start = 1'b0; ready = 1'b0; start2 = 1'b0; ready2 = 1'b0;
  endtask

  task automatic test_full_scan();
    int en_cnt = 0, done_cnt = 0, done_cyc = -1;
    beat_t b;
    sb.delete();
    push_scan(4, 4, 1, 1, 4);
    for (int cyc = 0; cyc < 70; cyc++) begin
      @(negedge CLK);
      start = (cyc == 0) || (cyc == 65);
      ready = 1'b1;
      abort = 1'b0;
      #1;
      if (stream_en) begin
        en_cnt++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL full_extra_beat cyc=%0d got a beat expected none", cyc);
        end else begin
          b = sb.pop_front();
          if (base_h !== b.bh || base_w !== b.bw || patch_last !== b.last) begin
            n_fail++;
            $display("FAIL full_beat cyc=%0d got (%0d,%0d,last=%0b) expected (%0d,%0d,last=%0b)",
                     cyc, base_h, base_w, patch_last, b.bh, b.bw, b.last);
          end
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (cyc == 67) begin
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL full_start_in_done got busy=%b expected 0", busy); end
      end
    end
    start = 1'b0;
    n_checks++; if (en_cnt != 64) begin n_fail++; $display("FAIL full_en_count got %0d expected 64", en_cnt); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL full_done_count got %0d expected 1", done_cnt); end
    n_checks++; if (done_cyc != 65) begin n_fail++; $display("FAIL full_done_cycle got %0d expected 65", done_cyc); end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL full_left_over got %0d beats expected 0", sb.size()); end
  endtask

  task automatic test_ready_toggle();
    int en_cnt = 0, run_cnt = 0, done_cnt = 0, done_cyc = -1;
    beat_t b;
    sb.delete();
    push_scan(4, 4, 1, 1, 4);
    for (int cyc = 0; cyc < 140; cyc++) begin
      @(negedge CLK);
      start = (cyc == 0);
      ready = (cyc % 2 == 0);
      #1;
      if (busy) run_cnt++;
      if (stream_en) begin
        en_cnt++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL toggle_extra_beat cyc=%0d got a beat expected none", cyc);
        end else begin
          b = sb.pop_front();
          if (base_h !== b.bh || base_w !== b.bw || patch_last !== b.last) begin
            n_fail++;
            $display("FAIL toggle_beat cyc=%0d got (%0d,%0d,last=%0b) expected (%0d,%0d,last=%0b)",
                     cyc, base_h, base_w, patch_last, b.bh, b.bw, b.last);
          end
        end
      end else if (busy && sb.size() > 0) begin
        n_checks++;
        if (base_h !== sb[0].bh || base_w !== sb[0].bw || patch_last !== 1'b0) begin
          n_fail++;
          $display("FAIL toggle_stall cyc=%0d got (%0d,%0d,last=%0b) expected (%0d,%0d,last=0)",
                   cyc, base_h, base_w, patch_last, sb[0].bh, sb[0].bw);
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
    ready = 1'b0;
    n_checks++; if (en_cnt != 64) begin n_fail++; $display("FAIL toggle_en_count got %0d expected 64", en_cnt); end
    n_checks++; if (run_cnt != 128) begin n_fail++; $display("FAIL toggle_run_cycles got %0d expected 128", run_cnt); end
    n_checks++; if (done_cnt != 1 || done_cyc != 129) begin n_fail++; $display("FAIL toggle_done got count=%0d cyc=%0d expected 1 129", done_cnt, done_cyc); end
  endtask

  task automatic test_stride();
    int last_cnt = 0, done_cnt = 0, done_cyc = -1;
    beat_t b;
    sb.delete();
    push_scan(2, 2, 2, 0, 2);
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge CLK);
      start2 = (cyc == 0);
      ready2 = 1'b1;
      #1;
      if (patch_last2) last_cnt++;
      if (stream_en2) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL stride_extra_beat cyc=%0d got a beat expected none", cyc);
        end else begin
          b = sb.pop_front();
          if (base_h2 !== b.bh || base_w2 !== b.bw || patch_last2 !== b.last) begin
            n_fail++;
            $display("FAIL stride_beat cyc=%0d got (%0d,%0d,last=%0b) expected (%0d,%0d,last=%0b)",
                     cyc, base_h2, base_w2, patch_last2, b.bh, b.bw, b.last);
          end
        end
      end
      if (done2) begin done_cnt++; done_cyc = cyc; end
    end
    ready2 = 1'b0;
    n_checks++; if (last_cnt != 4) begin n_fail++; $display("FAIL stride_patch_last got %0d expected 4", last_cnt); end
    n_checks++; if (done_cnt != 1 || done_cyc != 9) begin n_fail++; $display("FAIL stride_done got count=%0d cyc=%0d expected 1 9", done_cnt, done_cyc); end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL stride_left_over got %0d expected 0", sb.size()); end
  endtask

  task automatic test_abort();
    int done_cnt = 0, done_cyc = -1, en2 = 0;
    beat_t b;
    sb.delete();
    push_scan(4, 4, 1, 1, 4);
    for (int cyc = 0; cyc < 110; cyc++) begin
      @(negedge CLK);
      start = (cyc == 0) || (cyc == 30);
      abort = (cyc == 19);
      ready = 1'b1;
      #1;
      if (cyc == 20) begin
        n_checks++;
        if (busy !== 1'b0 || stream_en !== 1'b0 || done !== 1'b0) begin
          n_fail++; $display("FAIL abort_idle got busy=%b en=%b done=%b expected 0 0 0", busy, stream_en, done);
        end
        sb.delete();
        push_scan(4, 4, 1, 1, 4);
      end
      if (stream_en) begin
        if (cyc > 30) en2++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL abort_extra_beat cyc=%0d got a beat expected none", cyc);
        end else begin
          b = sb.pop_front();
          if (base_h !== b.bh || base_w !== b.bw || patch_last !== b.last) begin
            n_fail++;
            $display("FAIL abort_beat cyc=%0d got (%0d,%0d,last=%0b) expected (%0d,%0d,last=%0b)",
                     cyc, base_h, base_w, patch_last, b.bh, b.bw, b.last);
          end
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
    start = 1'b0; abort = 1'b0; ready = 1'b0;
    n_checks++; if (done_cnt != 1 || done_cyc != 95) begin n_fail++; $display("FAIL abort_done got count=%0d cyc=%0d expected 1 95", done_cnt, done_cyc); end
    n_checks++; if (en2 != 64) begin n_fail++; $display("FAIL abort_restart_beats got %0d expected 64", en2); end
  endtask

  task automatic test_reset_mid_run();
    int done_cnt = 0;
    beat_t b;
    sb.delete();
    push_scan(4, 4, 1, 1, 4);
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge CLK);
      start = (cyc <= 25);
      RST = (cyc == 25);
      ready = 1'b1;
      #1;
      if (stream_en) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL rst_extra_beat cyc=%0d got a beat expected none", cyc);
        end else begin
          b = sb.pop_front();
          if (base_h !== b.bh || base_w !== b.bw || patch_last !== b.last) begin
            n_fail++;
            $display("FAIL rst_beat cyc=%0d got (%0d,%0d,last=%0b) expected (%0d,%0d,last=%0b)",
                     cyc, base_h, base_w, patch_last, b.bh, b.bw, b.last);
          end
        end
      end
      if (cyc == 26) begin
        n_checks++;
        if (busy !== 1'b0 || stream_en !== 1'b0 || patch_last !== 1'b0 || base_h !== 0 || base_w !== 0) begin
          n_fail++;
          $display("FAIL rst_outputs got busy=%b en=%b last=%b base=(%0d,%0d) expected all 0",
                   busy, stream_en, patch_last, base_h, base_w);
        end
      end
      if (done) done_cnt++;
    end
    RST = 1'b0; start = 1'b0; ready = 1'b0;
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL rst_done got %0d expected 0", done_cnt); end
    n_checks++; if (sb.size() != 64 - 25) begin n_fail++; $display("FAIL rst_beats_consumed got %0d left expected %0d", sb.size(), 64 - 25); end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_ready_toggle();
    test_stride();
    test_abort();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
